uart_mem_streamer: RTL and testbench
====================================

# uart_mem_streamer

Parametrised memory-to-UART streamer. On a start pulse it reads a contiguous run of words from a synchronous-read block RAM, splits each word into bytes, and presents them one at a time to the UART transmitter over a valid/ready handshake. It sits between the instruction/data BRAM and the UART TX core. It serves as the loader/dump path for host-side inspection of memory contents.

## Interface
Parameters:
- DATA_W, 32, memory word width; must be a multiple of 8 and at least 8.
- ADDR_W, 10, memory address width.
- RD_LAT, 2, memory read latency in cycles; must be at least 1.
- MSB_FIRST, 0, byte order on the wire: 0 sends the least-significant byte first, 1 sends the most-significant byte first.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address; sampled with start.
- word_count  in  ADDR_W+1  number of words to send; sampled with start; 0 is legal.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the transfer completes.
- mem_addr  out  ADDR_W  BRAM read address.
- mem_rdata  in  DATA_W  BRAM read data; valid RD_LAT cycles after mem_addr changes.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  the UART accepts a byte when tx_valid and tx_ready are both high on a rising edge.

## Operation
- States:
  - IDLE: waits for start.
  - FETCH: waits RD_LAT cycles, then captures mem_rdata into a shift register.
  - SEND: emits DATA_W/8 bytes.
  - CSUM: present only with the macro.
  - FIN: raises the done pulse, then returns to IDLE.
- IDLE with start:
  - word_count is 0: go to FIN; no bytes are sent and no memory access is made.
  - Otherwise: load mem_addr with base_addr and the remaining counter with word_count, then go to FETCH.
- SEND:
  - tx_data and tx_valid come from registers.
  - Once tx_valid is high it stays high, with tx_data stable, until the handshake.
  - After each handshake the next byte is presented in the following cycle with no bubble.
- After the last byte of a word:
  - If words remain: mem_addr increments, wrapping modulo 2^ADDR_W, and the block returns to FETCH.
  - If no words remain: go to FIN, or to CSUM when the macro is defined.
- Requests are not queued: start while busy is ignored.
- Reset (at power-up or in the middle of a transfer) forces IDLE immediately. Reset values:
  - mem_addr=0, tx_data=0, tx_valid=0, busy=0, done=0.
  - The counters are cleared.
  - A partially sent word is abandoned.

## Timing
- Start accepted at edge E0:
  - mem_addr=base_addr and busy=1 after E0.
  - tx_valid rises after edge E0+RD_LAT+1, carrying the first byte.
- Gap between words: RD_LAT+1 cycles with tx_valid low, counted from the handshake of the last byte of a word to the first byte of the next word.
- With tx_ready held high, one word occupies DATA_W/8 + RD_LAT + 1 cycles.
- done is asserted for exactly one cycle, one cycle after the final handshake. busy falls in the same cycle done rises.
- With word_count=0, done is asserted one cycle after start is accepted.
- tx_ready is ignored while tx_valid is low.

## Configuration
- UART_MEM_STREAMER_CHECKSUM_EN defined:
  - A running XOR of every transmitted byte is kept; it is cleared when start is accepted.
  - After the last data byte, the block enters CSUM and sends the checksum as one extra byte under the same handshake, then goes to FIN.
  - With word_count=0 no checksum byte is sent.
- UART_MEM_STREAMER_CHECKSUM_EN undefined: no CSUM state and no XOR register; the byte stream consists only of data.

## Structure
- Package uart_mem_pkg holds:
  - the state enum (IDLE, FETCH, SEND, CSUM, FIN);
  - the byte-width constant (8);
  - a function that returns DATA_W/8.
- Sub-module uart_word_serializer holds the byte shift register, the byte index counter, MSB_FIRST selection and the tx_valid/tx_ready logic.
  - Inputs: a load pulse and a word.
  - Output: a last-byte-accepted pulse.
- The top level holds the state machine, the address and word counters, the RD_LAT wait counter and the optional checksum.

## Test plan
- RD_LAT=2, base_addr=0x3FE, word_count=3, tx_ready=1, memory holds 0x11223344, 0x55667788 and 0x99AABBCC at 0x3FE, 0x3FF and 0x000 (the address wraps). The bytes must be 44 33 22 11 88 77 66 55 CC BB AA 99. done must pulse once, one cycle after the last handshake.
- Same memory with MSB_FIRST=1 and word_count=1 at 0x3FE -> bytes 11 22 33 44.
- tx_ready toggles 1-of-3 cycles during the first test -> the same byte sequence. tx_data must never change while tx_valid is high and tx_ready is low.
- word_count=0 -> done is high one cycle after start. tx_valid and busy never rise, and mem_addr is unchanged.
- rstn pulsed low in the middle of the second byte -> tx_valid=0 and busy=0 immediately. A new start afterwards sends the full sequence from base_addr.
- Macro defined, word_count=1, word 0x11223344 -> bytes 44 33 22 11 followed by the checksum 0x44, then done.

Source files
------------

// File: rtl/uart_mem_pkg.sv
// Shared definitions for the memory-to-UART streamer: FSM state encoding,
// byte width and a helper giving the number of bytes per memory word.
package uart_mem_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        CSUM,
        FIN
    } state_t;

    function automatic int bytes_per_word(input int data_w);
        return data_w / BYTE_W;
    endfunction

endpackage

// File: rtl/uart_word_serializer.sv
// Splits one memory word into bytes and presents them on a registered
// valid/ready byte stream. MSB_FIRST selects which end of the word leaves first.
// last_acc pulses (combinationally) in the cycle whose rising edge accepts the
// final byte of the word.
module uart_word_serializer
    import uart_mem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load,
    input  logic [DATA_W-1:0] word,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    output logic              last_acc
);

    localparam int NB    = bytes_per_word(DATA_W);
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

    logic [DATA_W-1:0] shreg;
    logic [IDX_W-1:0]  idx;
    logic              hs;

    assign hs       = tx_valid && tx_ready;
    assign last_acc = hs && (idx == LAST_IDX);

    // Byte shift register: load a word, then advance one byte per handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg    <= '0;
            idx      <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else if (load) begin
            idx      <= '0;
            tx_valid <= 1'b1;
            if (MSB_FIRST != 0) begin
                tx_data <= word[DATA_W-1 -: BYTE_W];
                shreg   <= word << BYTE_W;
            end else begin
                tx_data <= word[BYTE_W-1:0];
                shreg   <= word >> BYTE_W;
            end
        end else if (hs) begin
            if (idx == LAST_IDX) begin
                tx_valid <= 1'b0;
            end else begin
                idx <= idx + 1'b1;
                if (MSB_FIRST != 0) begin
                    tx_data <= shreg[DATA_W-1 -: BYTE_W];
                    shreg   <= shreg << BYTE_W;
                end else begin
                    tx_data <= shreg[BYTE_W-1:0];
                    shreg   <= shreg >> BYTE_W;
                end
            end
        end
    end

endmodule

// File: rtl/uart_mem_streamer.sv
// Memory-to-UART streamer: on start, reads word_count words from a
// synchronous-read BRAM beginning at base_addr and streams their bytes out.
// Optional build macro UART_MEM_STREAMER_CHECKSUM_EN appends an XOR checksum
// byte after the data of every non-empty transfer.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start
// FETCH | address presented, counting down RD_LAT before capture
// SEND  | serializer emitting the bytes of the current word
// CSUM  | sending the checksum byte (checksum builds only)
// FIN   | one-cycle done pulse, then back to IDLE
module uart_mem_streamer
    import uart_mem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int RD_LAT    = 2,
    parameter int MSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int WAIT_W = $clog2(RD_LAT + 1);
    localparam logic [ADDR_W:0] ONE_WORD = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state, state_nxt;
    logic [ADDR_W:0]   words_left;
    logic [WAIT_W-1:0] wait_cnt;
    logic              ser_load;
    logic              ser_last;
    logic              ser_valid;
    logic [7:0]        ser_data;
    logic              last_word;

    assign last_word = (words_left == ONE_WORD);
    assign busy      = (state == FETCH) || (state == SEND) || (state == CSUM);
    assign done      = (state == FIN);

`ifdef UART_MEM_STREAMER_CHECKSUM_EN
    logic [7:0] csum;
    logic       csum_valid;
    logic       csum_hs;
    logic       accept;

    assign accept  = (state == IDLE) && start;
    assign csum_hs = csum_valid && tx_ready;
`endif

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; the serializer load fires on the terminal wait count.
    always_comb begin
        state_nxt = state;
        ser_load  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (word_count == '0) ? FIN : FETCH;
                end
            end
            FETCH: begin
                if (wait_cnt == '0) begin
                    ser_load  = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (ser_last) begin
                    if (!last_word) begin
                        state_nxt = FETCH;
                    end else begin
`ifdef UART_MEM_STREAMER_CHECKSUM_EN
                        state_nxt = CSUM;
`else
                        state_nxt = FIN;
`endif
                    end
                end
            end
            CSUM: begin
`ifdef UART_MEM_STREAMER_CHECKSUM_EN
                if (csum_hs) begin
                    state_nxt = FIN;
                end
`else
                state_nxt = IDLE;
`endif
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address, remaining-word and read-latency down-counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_addr   <= '0;
            words_left <= '0;
            wait_cnt   <= '0;
        end else if ((state == IDLE) && start && (word_count != '0)) begin
            mem_addr   <= base_addr;
            words_left <= word_count;
            wait_cnt   <= WAIT_W'(RD_LAT);
        end else if ((state == FETCH) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - 1'b1;
        end else if ((state == SEND) && ser_last) begin
            words_left <= words_left - 1'b1;
            if (!last_word) begin
                mem_addr <= mem_addr + 1'b1;
                wait_cnt <= WAIT_W'(RD_LAT);
            end
        end
    end

    uart_word_serializer #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_ser (
        .clk      (clk),
        .rstn     (rstn),
        .load     (ser_load),
        .word     (mem_rdata),
        .tx_ready (tx_ready),
        .tx_data  (ser_data),
        .tx_valid (ser_valid),
        .last_acc (ser_last)
    );

`ifdef UART_MEM_STREAMER_CHECKSUM_EN
    // Running XOR of sent data bytes; the checksum byte is raised right after
    // the last data byte so the stream has no bubble before it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            csum       <= '0;
            csum_valid <= 1'b0;
        end else begin
            if (accept) begin
                csum <= '0;
            end else if (ser_valid && tx_ready) begin
                csum <= csum ^ ser_data;
            end
            if ((state == SEND) && ser_last && last_word) begin
                csum_valid <= 1'b1;
            end else if (csum_hs) begin
                csum_valid <= 1'b0;
            end
        end
    end

    assign tx_valid = ser_valid | csum_valid;
    assign tx_data  = csum_valid ? csum : ser_data;
`else
    assign tx_valid = ser_valid;
    assign tx_data  = ser_data;
`endif

endmodule

// File: tb/tb_uart_mem_streamer.sv
// Bench for uart_mem_streamer: an LSB-first and an MSB-first instance share
// one memory image; a behavioural model predicts every byte, busy/done and
// the inter-word gap from the transfer parameters.
`timescale 1ns/1ps
module tb_uart_mem_streamer;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int RD_LAT = 2;
    localparam int NB     = DATA_W / 8;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef UART_MEM_STREAMER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic              start_s [2];
    logic [ADDR_W-1:0] base_s  [2];
    logic [ADDR_W:0]   cnt_s   [2];
    logic              busy_s  [2];
    logic              done_s  [2];
    logic [ADDR_W-1:0] addr_s  [2];
    logic [DATA_W-1:0] rdata_s [2];
    logic [7:0]        txd_s   [2];
    logic              txv_s   [2];
    logic              txr_s   [2];

    logic [DATA_W-1:0] mem  [DEPTH];
    logic [DATA_W-1:0] pipe [2][RD_LAT];

    int n_cmp = 0;
    int n_bad = 0;

    // model state, written only by the monitor
    bit         active   [2];
    bit         done_due [2];
    int         xb       [2];
    int         xc       [2];
    int         got      [2];
    int         gap      [2];
    bit         prev_stall [2];
    bit         prev_valid [2];
    logic [7:0] prev_data  [2];
    logic [7:0] rx_log [2][64];
    int         rx_n   [2];

    int ready_mode [2];

    uart_mem_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rstn(rstn), .start(start_s[0]), .base_addr(base_s[0]), .word_count(cnt_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .mem_addr(addr_s[0]), .mem_rdata(rdata_s[0]),
        .tx_data(txd_s[0]), .tx_valid(txv_s[0]), .tx_ready(txr_s[0]));

    uart_mem_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rstn(rstn), .start(start_s[1]), .base_addr(base_s[1]), .word_count(cnt_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .mem_addr(addr_s[1]), .mem_rdata(rdata_s[1]),
        .tx_data(txd_s[1]), .tx_valid(txv_s[1]), .tx_ready(txr_s[1]));

    // Synchronous-read memory with RD_LAT cycles of latency per port.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            pipe[g][0] <= mem[addr_s[g]];
            for (int i = 1; i < RD_LAT; i++) pipe[g][i] <= pipe[g][i-1];
        end
    end
    assign rdata_s[0] = pipe[0][RD_LAT-1];
    assign rdata_s[1] = pipe[1][RD_LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Byte k of a transfer: word k/NB, byte k%NB in wire order; past the data,
    // the XOR of every data byte.
    function automatic logic [7:0] exp_byte(input bit msb, input int base, input int cnt, input int k);
        logic [DATA_W-1:0] w;
        logic [7:0] x;
        int bi;
        if (k >= cnt * NB) begin
            x = 8'h00;
            for (int wi = 0; wi < cnt; wi++) begin
                w = mem[(base + wi) % DEPTH];
                for (int b = 0; b < NB; b++) x = x ^ w[8*b +: 8];
            end
            return x;
        end
        w  = mem[(base + k / NB) % DEPTH];
        bi = msb ? (NB - 1 - (k % NB)) : (k % NB);
        return w[8*bi +: 8];
    endfunction

    // Compare process: checks both DUTs against the model every cycle.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            int total;
            bit idle;
            if (!rstn) begin
                active[g] = 0; done_due[g] = 0; got[g] = 0;
                prev_stall[g] = 0; prev_valid[g] = 0;
            end else begin
                total = xc[g] * NB + ((CSUM_EN && xc[g] > 0) ? 1 : 0);
                check("busy", busy_s[g], active[g]);
                check("done", done_s[g], done_due[g]);
                if (!active[g]) check("tx_valid_idle", txv_s[g], 1'b0);
                if (prev_stall[g]) begin
                    check("hold_valid", txv_s[g], 1'b1);
                    check("hold_data", txd_s[g], prev_data[g]);
                end
                if (active[g] && got[g] < xc[g] * NB)
                    check("mem_addr", addr_s[g], (xb[g] + got[g] / NB) % DEPTH);
                if (active[g] && txv_s[g] && !prev_valid[g])
                    check("word_gap", gap[g], RD_LAT + 1);
                if (active[g] && !txv_s[g]) gap[g]++;
                idle = !active[g] && !done_due[g];
                done_due[g] = 0;
                if (active[g] && txv_s[g] && txr_s[g]) begin
                    check("byte", txd_s[g], exp_byte(g == 1, xb[g], xc[g], got[g]));
                    if (rx_n[g] < 64) begin
                        rx_log[g][rx_n[g]] = txd_s[g];
                        rx_n[g]++;
                    end
                    got[g]++;
                    if (got[g] == total) begin
                        active[g] = 0;
                        done_due[g] = 1;
                    end else if ((got[g] % NB == 0) && (got[g] < xc[g] * NB)) begin
                        gap[g] = 0;
                    end
                end
                if (idle && start_s[g]) begin
                    xb[g] = int'(base_s[g]); xc[g] = int'(cnt_s[g]);
                    got[g] = 0; gap[g] = 0; rx_n[g] = 0;
                    if (cnt_s[g] == 0) done_due[g] = 1;
                    else active[g] = 1;
                end
                prev_stall[g] = txv_s[g] && !txr_s[g];
                prev_valid[g] = txv_s[g];
                prev_data[g]  = txd_s[g];
            end
        end
    end

    // tx_ready pattern generator: 0 = always, 1 = one cycle in three, 2 = random.
    initial begin
        int cyc = 0;
        txr_s[0] = 1'b1; txr_s[1] = 1'b1;
        forever begin
            @(posedge clk); #1;
            cyc++;
            for (int g = 0; g < 2; g++) begin
                case (ready_mode[g])
                    0:       txr_s[g] = 1'b1;
                    1:       txr_s[g] = (cyc % 3 == 0);
                    default: txr_s[g] = ($urandom_range(0, 1) == 1);
                endcase
            end
        end
    end

    task automatic go(input int g, input int base, input int cnt);
        @(posedge clk); #1;
        start_s[g] = 1'b1;
        base_s[g]  = ADDR_W'(base);
        cnt_s[g]   = (ADDR_W+1)'(cnt);
        @(posedge clk); #1;
        start_s[g] = 1'b0;
        base_s[g]  = ADDR_W'($urandom);
        cnt_s[g]   = (ADDR_W+1)'($urandom);
    endtask

    task automatic wait_idle(input int g, input string name);
        int n = 0;
        while ((active[g] || done_due[g]) && n < 5000) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 5000) begin
            n_cmp++; n_bad++;
            $display("FAIL %s timeout: transfer still running after %0d cycles", name, n);
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic check_seq(input int g, input string name, input logic [7:0] exp [], input logic [7:0] csum);
        check({name, "_len"}, rx_n[g], exp.size() + (CSUM_EN ? 1 : 0));
        for (int i = 0; i < exp.size(); i++) check(name, rx_log[g][i], exp[i]);
        if (CSUM_EN) check({name, "_csum"}, rx_log[g][exp.size()], csum);
    endtask

    logic [7:0] seq_lsb [] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55,
                               8'hCC, 8'hBB, 8'hAA, 8'h99};
    logic [7:0] seq_msb [] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        int n;
        for (int g = 0; g < 2; g++) begin
            start_s[g] = 1'b0; base_s[g] = '0; cnt_s[g] = '0;
            ready_mode[g] = 0; rx_n[g] = 0; xb[g] = 0; xc[g] = 0;
        end
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("rst_busy", busy_s[g], 1'b0);
            check("rst_done", done_s[g], 1'b0);
            check("rst_valid", txv_s[g], 1'b0);
            check("rst_addr", addr_s[g], 10'h000);
            check("rst_data", txd_s[g], 8'h00);
        end
        @(posedge clk); #1 rstn = 1'b1;

        mem[10'h3FE] = 32'h11223344;
        mem[10'h3FF] = 32'h55667788;
        mem[10'h000] = 32'h99AABBCC;

        // three words across the address wrap, ready held high
        go(0, 10'h3FE, 3);
        wait_idle(0, "wrap");
        check_seq(0, "wrap_seq", seq_lsb, 8'hCC);

        // same transfer with back-pressure
        ready_mode[0] = 1;
        go(0, 10'h3FE, 3);
        wait_idle(0, "stall");
        check_seq(0, "stall_seq", seq_lsb, 8'hCC);
        ready_mode[0] = 0;

        // MSB-first instance, one word
        go(1, 10'h3FE, 1);
        wait_idle(1, "msb");
        check_seq(1, "msb_seq", seq_msb, 8'h44);

        // empty transfer leaves the address alone
        go(0, 10'h123, 0);
        wait_idle(0, "zero");
        check("zero_addr", addr_s[0], 10'h000);

        // reset while the second byte is on the wire
        go(0, 10'h3FE, 3);
        n = 0;
        while (!(got[0] == 1 && txv_s[0]) && n < 100) begin @(negedge clk); #1; n++; end
        check("mid_reached", (n < 100), 1'b1);
        rstn = 1'b0;
        #1;
        check("mid_rst_valid", txv_s[0], 1'b0);
        check("mid_rst_busy", busy_s[0], 1'b0);
        @(negedge clk);
        @(posedge clk); #1 rstn = 1'b1;
        go(0, 10'h3FE, 3);
        wait_idle(0, "after_rst");
        check_seq(0, "after_rst_seq", seq_lsb, 8'hCC);

        // a second start during a transfer is ignored
        go(0, 10'h010, 4);
        repeat (5) @(posedge clk);
        go(0, 10'h200, 2);
        wait_idle(0, "ignored_start");
        check("ignored_len", rx_n[0], 16 + (CSUM_EN ? 1 : 0));

        // randomized transfers on both instances
        for (int it = 0; it < 40; it++) begin
            int g;
            g = $urandom_range(0, 1);
            for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
            ready_mode[g] = $urandom_range(0, 2);
            go(g, $urandom_range(0, DEPTH - 1), $urandom_range(0, 6));
            wait_idle(g, "random");
            ready_mode[g] = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
